// File: rtl/my_controller.sv
// my_controller: ROM-driven 5-phase register machine; ports clk, reset, mar, rd_sel, wr_sel, a, b, c, out; `MYCONTROLLER_JZ_EN enables the JZ branch
module my_controller (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] mar,
  output logic [3:0] rd_sel,
  output logic [3:0] wr_sel,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] out
);
  typedef enum logic [2:0] {S_FETCH, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_HALT} state_t;
  state_t r_state = S_FETCH;
  state_t w_next;
  logic [15:0] r_ir = '0;
  logic [3:0] r_mar = '0;
  logic [7:0] r_a = '0;
  logic [7:0] r_b = '0;
  logic [7:0] r_c = '0;
  logic [7:0] r_out = '0;
  logic [7:0] r_rf [16] = '{default: 8'h00};
  logic [15:0] w_rom;
  logic [3:0] w_op;
  logic [3:0] w_mar_next;
  logic [7:0] w_rd_data;
  logic [7:0] w_alu;
  logic w_wr;
  logic w_taken;
  function automatic logic [15:0] rom(input logic [3:0] addr);
    case (addr)
      4'd0: rom = 16'h1105;
      4'd1: rom = 16'h1203;
      4'd2: rom = 16'h2312;
      4'd3: rom = 16'h8030;
      4'd4: rom = 16'h3412;
      4'd5: rom = 16'h8040;
      4'd6: rom = 16'hF000;
      default: rom = 16'h0000;
    endcase
  endfunction
  assign w_rom = rom(r_mar);
  assign w_op = r_ir[15:12];
  assign w_wr = (w_op >= 4'h1) && (w_op <= 4'h7);
  assign w_rd_data = (rd_sel == 4'd0) ? 8'h00 : r_rf[rd_sel];
`ifdef MYCONTROLLER_JZ_EN
  assign w_taken = (w_op == 4'h9) || ((w_op == 4'hA) && (r_a == 8'h00));
`else
  assign w_taken = (w_op == 4'h9);
`endif
  assign w_mar_next = (w_op == 4'hF) ? r_mar : w_taken ? r_ir[3:0] : r_mar + 4'd1;
  always_comb begin
    case (w_op)
      4'h1: w_alu = r_ir[7:0];
      4'h2: w_alu = r_a + r_b;
      4'h3: w_alu = r_a - r_b;
      4'h4: w_alu = r_a & r_b;
      4'h5: w_alu = r_a | r_b;
      4'h6: w_alu = r_a ^ r_b;
      4'h7, 4'h8: w_alu = r_a;
      default: w_alu = r_c;
    endcase
  end
  always_comb begin
    w_next = r_state;
    rd_sel = 4'd0;
    wr_sel = 4'd0;
    case (r_state)
      S_FETCH: w_next = S_READ_A;
      S_READ_A: begin
        rd_sel = r_ir[7:4];
        w_next = S_READ_B;
      end
      S_READ_B: begin
        rd_sel = r_ir[3:0];
        w_next = S_EXEC;
      end
      S_EXEC: w_next = S_WRITE;
      S_WRITE: begin
        wr_sel = w_wr ? r_ir[11:8] : 4'd0;
        w_next = (w_op == 4'hF) ? S_HALT : S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? S_FETCH : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= '0;
      r_mar <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_out <= '0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else begin
      if (r_state == S_FETCH) r_ir <= w_rom;
      if (r_state == S_READ_A) r_a <= w_rd_data;
      if (r_state == S_READ_B) r_b <= w_rd_data;
      if (r_state == S_EXEC) r_c <= w_alu;
      if (r_state == S_WRITE) begin
        if (wr_sel != 4'd0) r_rf[wr_sel] <= r_c;
        if (w_op == 4'h8) r_out <= r_c;
        r_mar <= w_mar_next;
      end
    end
  end
  assign mar = r_mar;
  assign a = r_a;
  assign b = r_b;
  assign c = r_c;
  assign out = r_out;
endmodule

// File: tb/tb_my_controller.sv
// tb_my_controller: directed self-checking bench for my_controller
module tb_my_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] mar, rd_sel, wr_sel;
  logic [7:0] a, b, c, out;
  int n_vec = 0;
  int n_err = 0;
`ifdef MYCONTROLLER_JZ_EN
  localparam logic [3:0] JZ_MAR = 4'd9;
`else
  localparam logic [3:0] JZ_MAR = 4'd1;
`endif
  my_controller dut (
    .clk(clk), .reset(reset), .mar(mar), .rd_sel(rd_sel), .wr_sel(wr_sel),
    .a(a), .b(b), .c(c), .out(out)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask
  task automatic check_cleared(input string tag);
    n_vec++;
    if ({mar, rd_sel, wr_sel, a, b, c, out} !== 44'd0) begin
      n_err++;
      $display("FAIL %s_clear got mar=%0d rd=%0d wr=%0d a=%0d b=%0d c=%0d out=%0d want all 0", tag, mar, rd_sel, wr_sel, a, b, c, out);
    end
    n_vec++;
    if (dut.r_state !== dut.S_FETCH) begin
      n_err++;
      $display("FAIL %s_state got %0d want FETCH", tag, dut.r_state);
    end
  endtask
  task automatic run_program(input string tag);
    tick(5);
    n_vec++;
    if (mar !== 4'd1) begin n_err++; $display("FAIL %s_mar_e5 got %0d want 1", tag, mar); end
    tick(5);
    n_vec++;
    if (mar !== 4'd2) begin n_err++; $display("FAIL %s_mar_e10 got %0d want 2", tag, mar); end
    tick(4);
    n_vec++;
    if ({c, wr_sel} !== {8'd8, 4'd3}) begin n_err++; $display("FAIL %s_add_write got c=%0d wr=%0d want c=8 wr=3", tag, c, wr_sel); end
    tick(1);
    n_vec++;
    if ({c, wr_sel} !== {8'd8, 4'd0}) begin n_err++; $display("FAIL %s_e15 got c=%0d wr=%0d want c=8 wr=0", tag, c, wr_sel); end
    tick(5);
    n_vec++;
    if (out !== 8'd8) begin n_err++; $display("FAIL %s_out_e20 got %0d want 8", tag, out); end
    tick(5);
    n_vec++;
    if (c !== 8'd2) begin n_err++; $display("FAIL %s_c_e25 got %0d want 2", tag, c); end
    tick(5);
    n_vec++;
    if (out !== 8'd2) begin n_err++; $display("FAIL %s_out_e30 got %0d want 2", tag, out); end
    tick(5);
    n_vec++;
    if (mar !== 4'd6 || dut.r_state !== dut.S_HALT) begin n_err++; $display("FAIL %s_halt got mar=%0d state=%0d want mar=6 HALT", tag, mar, dut.r_state); end
  endtask
  task automatic test_reset();
    do_reset(2);
    check_cleared("reset");
  endtask
  task automatic test_program();
    run_program("prog");
  endtask
  task automatic test_halt_stable();
    for (int i = 0; i < 22; i++) begin
      tick(1);
      n_vec++;
      if ({mar, out, c, a, b, rd_sel, wr_sel} !== {4'd6, 8'd2, 8'd2, 8'd0, 8'd0, 4'd0, 4'd0}) begin
        n_err++;
        $display("FAIL halt_stable%0d got mar=%0d out=%0d c=%0d a=%0d b=%0d want 6 2 2 0 0", i, mar, out, c, a, b);
      end
    end
  endtask
  task automatic test_phase_selects();
    do_reset(1);
    tick(11);
    n_vec++;
    if (rd_sel !== 4'd1) begin n_err++; $display("FAIL rd_sel_a got %0d want 1", rd_sel); end
    tick(1);
    n_vec++;
    if ({rd_sel, a} !== {4'd2, 8'd5}) begin n_err++; $display("FAIL rd_sel_b got rd=%0d a=%0d want rd=2 a=5", rd_sel, a); end
    tick(1);
    n_vec++;
    if ({rd_sel, b} !== {4'd0, 8'd3}) begin n_err++; $display("FAIL exec_b got rd=%0d b=%0d want rd=0 b=3", rd_sel, b); end
  endtask
  task automatic test_reset_halt();
    tick(30);
    do_reset(1);
    check_cleared("rst_halt");
    run_program("rerun_halt");
  endtask
  task automatic test_reset_exec();
    do_reset(1);
    tick(13);
    n_vec++;
    if (dut.r_state !== dut.S_EXEC) begin n_err++; $display("FAIL exec_phase got state=%0d want EXEC", dut.r_state); end
    do_reset(1);
    check_cleared("rst_exec");
    n_vec++;
    if (dut.r_rf[3] !== 8'd0) begin n_err++; $display("FAIL rst_exec_r3 got %0d want 0", dut.r_rf[3]); end
    run_program("rerun_exec");
  endtask
  task automatic test_jz();
    do_reset(1);
    force dut.w_rom = 16'hA009;
    tick(1);
    release dut.w_rom;
    tick(4);
    n_vec++;
    if (mar !== JZ_MAR) begin n_err++; $display("FAIL jz_mar got %0d want %0d", mar, JZ_MAR); end
  endtask
  task automatic test_sub_wrap();
    do_reset(1);
    tick(10);
    force dut.w_rom = 16'h3421;
    tick(1);
    release dut.w_rom;
    tick(3);
    n_vec++;
    if ({c, wr_sel} !== {8'd254, 4'd4}) begin n_err++; $display("FAIL sub_wrap got c=%0d wr=%0d want c=254 wr=4", c, wr_sel); end
  endtask
  initial begin
    test_reset();
    test_program();
    test_halt_stable();
    test_reset_halt();
    test_phase_selects();
    test_reset_exec();
    test_jz();
    test_sub_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
